// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and operand payload layout for the systolic run controller.
package systolic_pkg;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned N        = 4;
   localparam int unsigned NUM_ELEM = N * N;
   localparam int unsigned ELEM_W   = $clog2(NUM_ELEM);
   localparam int unsigned BUS_W    = NUM_ELEM * WIDTH;
   localparam int unsigned IN_W     = 6 * WIDTH;

   // Field offsets inside in_data, A_INT in the most significant slot
   localparam int unsigned OFS_A_INT  = 5 * WIDTH;
   localparam int unsigned OFS_A_FRAC = 4 * WIDTH;
   localparam int unsigned OFS_B_INT  = 3 * WIDTH;
   localparam int unsigned OFS_B_FRAC = 2 * WIDTH;
   localparam int unsigned OFS_C_INT  = 1 * WIDTH;
   localparam int unsigned OFS_C_FRAC = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CLEAR = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_e;

   typedef struct packed {
      logic [WIDTH-1:0] a_int;
      logic [WIDTH-1:0] a_frac;
      logic [WIDTH-1:0] b_int;
      logic [WIDTH-1:0] b_frac;
      logic [WIDTH-1:0] c_int;
      logic [WIDTH-1:0] c_frac;
   } operand_t;

endpackage

// File: rtl/operand_bank.sv
// N*N entry register file holding one element of all six operand matrices per entry,
// presented to the arrays as flat row-major buses.
module operand_bank
   import systolic_pkg::*;
(
   input  logic              clk,
   input  logic              _reset,
   input  logic              wr_en,
   input  logic [ELEM_W-1:0] wr_idx,
   input  logic [IN_W-1:0]   wr_data,
   output logic [BUS_W-1:0]  a_int,
   output logic [BUS_W-1:0]  a_frac,
   output logic [BUS_W-1:0]  b_int,
   output logic [BUS_W-1:0]  b_frac,
   output logic [BUS_W-1:0]  c_int,
   output logic [BUS_W-1:0]  c_frac
);

   operand_t mem [NUM_ELEM];
   operand_t wr_elem;

   always_comb begin
      wr_elem        = '0;
      wr_elem.a_int  = wr_data[OFS_A_INT  +: WIDTH];
      wr_elem.a_frac = wr_data[OFS_A_FRAC +: WIDTH];
      wr_elem.b_int  = wr_data[OFS_B_INT  +: WIDTH];
      wr_elem.b_frac = wr_data[OFS_B_FRAC +: WIDTH];
      wr_elem.c_int  = wr_data[OFS_C_INT  +: WIDTH];
      wr_elem.c_frac = wr_data[OFS_C_FRAC +: WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!_reset) begin
         for (int e = 0; e < int'(NUM_ELEM); e++) mem[e] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_elem;
      end
   end

   // Flatten entries onto the buses; pure wiring from the flops
   always_comb begin
      a_int  = '0;
      a_frac = '0;
      b_int  = '0;
      b_frac = '0;
      c_int  = '0;
      c_frac = '0;
      for (int e = 0; e < int'(NUM_ELEM); e++) begin
         a_int [e*WIDTH +: WIDTH] = mem[e].a_int;
         a_frac[e*WIDTH +: WIDTH] = mem[e].a_frac;
         b_int [e*WIDTH +: WIDTH] = mem[e].b_int;
         b_frac[e*WIDTH +: WIDTH] = mem[e].b_frac;
         c_int [e*WIDTH +: WIDTH] = mem[e].c_int;
         c_frac[e*WIDTH +: WIDTH] = mem[e].c_frac;
      end
   end

endmodule

// File: rtl/systolic_run_ctrl.sv
// Job sequencer for the three 4x4 systolic arrays: loads operands, clears accumulators,
// waits for all arrays to finish, then hands the result to arrayMean.
module systolic_run_ctrl
   import systolic_pkg::*;
#(
   parameter int unsigned MIN_RUN = 10,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             _reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic [BUS_W-1:0] a_int,
   output logic [BUS_W-1:0] a_frac,
   output logic [BUS_W-1:0] b_int,
   output logic [BUS_W-1:0] b_frac,
   output logic [BUS_W-1:0] c_int,
   output logic [BUS_W-1:0] c_frac,
   output logic             _flush_acc,
   input  logic             done1,
   input  logic             done2,
   input  logic             done3,
   output logic             endofINT_INT_Mat,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic             err
);

   localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);

   state_e             state_q;
   state_e             state_n;
   logic [ELEM_W-1:0]  elem_q;
   logic [RUN_W-1:0]   run_q;
   logic               wr_en;
   logic               done_all;
   logic               timeout_hit;

   assign wr_en    = (state_q == LOAD) && in_valid;
   assign done_all = done1 & done2 & done3;

   operand_bank u_bank (
      .clk     (clk),
      ._reset  (_reset),
      .wr_en   (wr_en),
      .wr_idx  (elem_q),
      .wr_data (in_data),
      .a_int   (a_int),
      .a_frac  (a_frac),
      .b_int   (b_int),
      .b_frac  (b_frac),
      .c_int   (c_int),
      .c_frac  (c_frac)
   );

   // Next-state logic; completion takes priority over timeout in the same cycle
   always_comb begin
      state_n     = state_q;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE:  if (start) state_n = LOAD;
         LOAD:  if (in_valid && elem_q == ELEM_W'(NUM_ELEM - 1)) state_n = CLEAR;
         CLEAR: state_n = RUN;
         RUN: begin
            if (done_all && run_q >= RUN_W'(MIN_RUN)) begin
               state_n = DONE;
            end else if (run_q == RUN_W'(TIMEOUT - 1)) begin
               state_n     = IDLE;
               timeout_hit = 1'b1;
            end
         end
         DONE:  if (res_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State, counters and registered outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (!_reset) begin
         state_q          <= IDLE;
         elem_q           <= '0;
         run_q            <= '0;
         in_ready         <= 1'b0;
         _flush_acc       <= 1'b1;
         endofINT_INT_Mat <= 1'b0;
         res_valid        <= 1'b0;
         busy             <= 1'b0;
         err              <= 1'b0;
      end else begin
         state_q <= state_n;

         if (state_q == IDLE && start)  elem_q <= '0;
         else if (wr_en)                elem_q <= elem_q + ELEM_W'(1);

         if (state_q == CLEAR)                          run_q <= '0;
         else if (state_q == RUN && run_q != RUN_W'(TIMEOUT)) run_q <= run_q + RUN_W'(1);

         if (state_q == IDLE && start) err <= 1'b0;
         else if (timeout_hit)         err <= 1'b1;

         in_ready         <= (state_n == LOAD);
         _flush_acc       <= (state_n != CLEAR);
         endofINT_INT_Mat <= (state_n == DONE);
         res_valid        <= (state_n == DONE);
         busy             <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_systolic_run_ctrl.sv
// Scoreboard bench for systolic_run_ctrl: each job's expected operand buses are queued
// while beats are driven and compared when the job ends.
module tb_systolic_run_ctrl;
   import systolic_pkg::*;

   localparam int unsigned MIN_RUN = 10;
   localparam int unsigned TIMEOUT = 64;

   logic             clk = 1'b0;
   logic             _reset;
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [BUS_W-1:0] a_int, a_frac, b_int, b_frac, c_int, c_frac;
   logic             _flush_acc;
   logic             done1, done2, done3;
   logic             endofINT_INT_Mat;
   logic             res_valid;
   logic             res_ready;
   logic             busy;
   logic             err;

   always #5 clk = ~clk;

   systolic_run_ctrl #(.MIN_RUN(MIN_RUN), .TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      ._reset           (_reset),
      .start            (start),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .a_int            (a_int),
      .a_frac           (a_frac),
      .b_int            (b_int),
      .b_frac           (b_frac),
      .c_int            (c_int),
      .c_frac           (c_frac),
      ._flush_acc       (_flush_acc),
      .done1            (done1),
      .done2            (done2),
      .done3            (done3),
      .endofINT_INT_Mat (endofINT_INT_Mat),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .busy             (busy),
      .err              (err)
   );

   typedef struct {
      logic [BUS_W-1:0] a_int, a_frac, b_int, b_frac, c_int, c_frac;
   } job_t;

   job_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_buses(input string tag, input job_t exp);
      check({tag, "_a_int"},  a_int,  exp.a_int);
      check({tag, "_a_frac"}, a_frac, exp.a_frac);
      check({tag, "_b_int"},  b_int,  exp.b_int);
      check({tag, "_b_frac"}, b_frac, exp.b_frac);
      check({tag, "_c_int"},  c_int,  exp.c_int);
      check({tag, "_c_frac"}, c_frac, exp.c_frac);
   endtask

   // done_at < 0 means done2 never rises; rst_at >= 0 pulses reset in that RUN cycle
   task automatic run_job(input bit bp, input int done_at, input int hold, input int rst_at,
                          input bit start_in_done, input bit fixed_data);
      job_t             exp;
      job_t             got_job;
      logic [WIDTH-1:0] v [6];
      int               n, cyc, lost, r, dn, eo_bad, exp_r;

      exp = '{default: '0};
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_clear_on_start", BUS_W'(err), BUS_W'(0));

      n = 0; cyc = 0; lost = 0;
      while (n < int'(NUM_ELEM) && cyc < 100) begin
         if (cyc > 0) @(negedge clk);
         if (!in_ready) lost++;
         start    = bp && (cyc == 3);
         in_valid = !bp || (cyc % 2 == 0);
         if (in_valid) begin
            for (int f = 0; f < 6; f++) v[f] = fixed_data ? '0 : WIDTH'($urandom);
            if (fixed_data) begin
               v[0] = WIDTH'(n);
               v[2] = WIDTH'(1);
            end
            in_data = {v[0], v[1], v[2], v[3], v[4], v[5]};
            exp.a_int [n*WIDTH +: WIDTH] = v[0];
            exp.a_frac[n*WIDTH +: WIDTH] = v[1];
            exp.b_int [n*WIDTH +: WIDTH] = v[2];
            exp.b_frac[n*WIDTH +: WIDTH] = v[3];
            exp.c_int [n*WIDTH +: WIDTH] = v[4];
            exp.c_frac[n*WIDTH +: WIDTH] = v[5];
            n++;
         end
         cyc++;
      end
      sb.push_back(exp);

      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = '0;
      check("load_cycles", BUS_W'(cyc), BUS_W'(bp ? 31 : 16));
      check("in_ready_during_load", BUS_W'(lost), BUS_W'(0));
      check("in_ready_after_load", BUS_W'(in_ready), BUS_W'(0));
      check("flush_in_clear", BUS_W'(_flush_acc), BUS_W'(0));

      r = 0;
      while (r < 200) begin
         @(negedge clk);
         if (r == 0) check("flush_one_cycle", BUS_W'(_flush_acc), BUS_W'(1));
         if (res_valid || !busy) break;
         if (r == rst_at) _reset = 1'b0;
         done1     = (done_at < 0) || (r >= done_at);
         done3     = done1;
         done2     = (done_at >= 0) && (r >= done_at);
         res_ready = (hold == 0);
         r++;
      end
      done1 = 1'b0; done2 = 1'b0; done3 = 1'b0;

      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      got_job = sb.pop_front();

      if (rst_at >= 0) begin
         _reset = 1'b1;
         check("rst_run_cycles", BUS_W'(r), BUS_W'(rst_at + 1));
         check("rst_busy", BUS_W'(busy), BUS_W'(0));
         check("rst_flush", BUS_W'(_flush_acc), BUS_W'(1));
         check("rst_res_valid", BUS_W'(res_valid), BUS_W'(0));
         check("rst_in_ready", BUS_W'(in_ready), BUS_W'(0));
         check_buses("rst_bus", '{default: '0});
      end else if (done_at < 0) begin
         check("timeout_run_cycles", BUS_W'(r), BUS_W'(TIMEOUT));
         check("timeout_err", BUS_W'(err), BUS_W'(1));
         check("timeout_busy", BUS_W'(busy), BUS_W'(0));
         check("timeout_res_valid", BUS_W'(res_valid), BUS_W'(0));
         check_buses("timeout_hold", got_job);
      end else begin
         exp_r = ((done_at > int'(MIN_RUN)) ? done_at : int'(MIN_RUN)) + 1;
         check("run_cycles", BUS_W'(r), BUS_W'(exp_r));
         check("res_valid_rise", BUS_W'(res_valid), BUS_W'(1));
         check("endof_rise", BUS_W'(endofINT_INT_Mat), BUS_W'(1));
         check("err_after_done", BUS_W'(err), BUS_W'(0));
         check_buses("result", got_job);
         dn = 0; eo_bad = 0;
         while (res_valid && dn < 50) begin
            if (!endofINT_INT_Mat) eo_bad++;
            res_ready = (dn >= hold);
            start     = start_in_done && (dn == hold);
            dn++;
            @(negedge clk);
         end
         res_ready = 1'b0;
         start     = 1'b0;
         check("done_cycles", BUS_W'(dn), BUS_W'(hold + 1));
         check("endof_held", BUS_W'(eo_bad), BUS_W'(0));
         check("endof_drop", BUS_W'(endofINT_INT_Mat), BUS_W'(0));
         check("idle_after_done", BUS_W'(busy), BUS_W'(0));
         if (start_in_done) begin
            repeat (2) @(negedge clk);
            check("no_second_job_busy", BUS_W'(busy), BUS_W'(0));
            check("no_second_job_ready", BUS_W'(in_ready), BUS_W'(0));
         end
      end
   endtask

   initial begin
      logic [BUS_W-1:0] elem;
      _reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      done1 = 1'b0; done2 = 1'b0; done3 = 1'b0; res_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy", BUS_W'(busy), BUS_W'(0));
      check("reset_in_ready", BUS_W'(in_ready), BUS_W'(0));
      check("reset_flush", BUS_W'(_flush_acc), BUS_W'(1));
      check("reset_res_valid", BUS_W'(res_valid), BUS_W'(0));
      check("reset_endof", BUS_W'(endofINT_INT_Mat), BUS_W'(0));
      check("reset_err", BUS_W'(err), BUS_W'(0));
      check_buses("reset_bus", '{default: '0});
      _reset = 1'b1;

      run_job(1'b0, 12, 0, -1, 1'b0, 1'b1);      // nominal
      elem = '0;
      elem[WIDTH-1:0] = a_int[(2*N+3)*WIDTH +: WIDTH];
      check("a_int_elem_2_3", elem, BUS_W'(8'h0B));
      run_job(1'b1, 12, 5, -1, 1'b1, 1'b0);      // backpressure, held DONE, ignored starts
      run_job(1'b0, 0, 0, -1, 1'b0, 1'b0);       // early done
      run_job(1'b0, -1, 0, -1, 1'b0, 1'b0);      // timeout
      run_job(1'b0, 15, 2, -1, 1'b0, 1'b0);      // start after timeout clears err
      run_job(1'b0, -1, 0, 5, 1'b0, 1'b0);       // reset mid-RUN
      run_job(1'b0, 11, 1, -1, 1'b0, 1'b0);      // recovery after reset

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
